// File: rtl/itch_pkt_parser.sv
// Byte-serial ITCH feed parser: Ethernet -> IPv4 -> UDP -> MoldUDP64 -> decoded ITCH A/E/X records.
// Build option: define IP_CHKSUM_EN to verify the IPv4 header checksum and drop frames that fail it.
module itch_pkt_parser #(
  parameter logic [47:0] MAC_ADDR        = 48'h01005E7D8B20,
  parameter logic [31:0] IP_ADDR         = 32'h8AFD8B20,
  parameter logic [15:0] UDP_PORT        = 16'h4696,
  parameter logic        STOCK_FILTER_EN = 1'b1,
  parameter logic [63:0] FILTER_STOCK    = 64'h4141504C00000000,
  parameter int unsigned MAX_MSG_LEN     = 64,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [7:0]       inByte,
  input  logic             inValid,
  input  logic             inSof,
  input  logic             inLast,
  output logic             outValid,
  output logic [7:0]       outMsgType,
  output logic [63:0]      outRefNum,
  output logic [7:0]       outBuySell,
  output logic [31:0]      outShares,
  output logic [31:0]      outPrice,
  output logic [63:0]      outStock,
  output logic [63:0]      outSeqNum,
  output logic [CNT_W-1:0] dropCnt,
  output logic [CNT_W-1:0] truncCnt
);
  localparam int unsigned CAP_BYTES = 36;

  typedef enum logic [3:0] {IDLE, ETH, IP, UDP, MOLD, MLEN, BODY, TAIL, DROP} state_e;

  state_e                   state_q;
  logic [15:0]              cnt_q, pos;
  logic [55:0]              sh_q;
  logic [63:0]              sh_d;
  logic [8*CAP_BYTES-1:0]   cap_q, cap_d;
  logic [15:0]              len_q, msgcnt_q, idx_q;
  logic [63:0]              seq_q;
  logic                     valid_q;
  logic [7:0]               type_q, bs_q;
  logic [63:0]              ref_q, stock_q, seqn_q;
  logic [31:0]              shares_q, price_q;
  logic [CNT_W-1:0]         drop_q, trunc_q;

  logic [7:0]               d_type, d_bs;
  logic [63:0]              d_ref, d_stock;
  logic [31:0]              d_shares, d_price;
  logic                     sec_end, hdr_fail, mold_err, frame_done, last_msg;
  logic                     is_add, is_ex, emit, csum_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Body bytes land at their message offset so decode uses fixed field positions.
  always_comb begin
    sh_d  = {sh_q, inByte};
    pos   = cnt_q + 16'd1;
    cap_d = cap_q;
    for (int unsigned i = 0; i < CAP_BYTES; i++)
      if (cnt_q == 16'(i)) cap_d[8*(CAP_BYTES-1-i) +: 8] = inByte;
  end

  assign d_type   = cap_d[287:280];
  assign d_ref    = cap_d[199:136];
  assign d_bs     = cap_d[135:128];
  assign d_shares = cap_d[127:96];
  assign d_stock  = cap_d[95:32];
  assign d_price  = cap_d[31:0];

  assign is_add = (d_type == 8'h41) && (len_q >= 16'd36) &&
                  (!STOCK_FILTER_EN || d_stock == FILTER_STOCK);
  assign is_ex  = (d_type == 8'h45 || d_type == 8'h58) && (len_q >= 16'd19);

  always_comb begin
    sec_end  = 1'b0;
    hdr_fail = 1'b0;
    case (state_q)
      ETH: begin
        sec_end  = (pos == 16'd14);
        hdr_fail = (pos == 16'd6  && sh_d[47:0] != MAC_ADDR) ||
                   (pos == 16'd14 && sh_d[15:0] != 16'h0800);
      end
      IP: begin
        sec_end  = (pos == 16'd20);
        hdr_fail = (pos == 16'd1  && sh_d[7:0] != 8'h45) ||
                   (pos == 16'd10 && sh_d[7:0] != 8'h11) ||
                   (pos == 16'd20 && (sh_d[31:0] != IP_ADDR || csum_bad));
      end
      UDP: begin
        sec_end  = (pos == 16'd8);
        hdr_fail = (pos == 16'd4 && sh_d[15:0] != UDP_PORT);
      end
      MOLD:    sec_end = (pos == 16'd20);
      MLEN:    sec_end = (pos == 16'd2);
      BODY:    sec_end = (pos == len_q);
      default: ;
    endcase
  end

  assign last_msg   = (idx_q + 16'd1 == msgcnt_q);
  assign mold_err   = (state_q == MLEN) && (pos == 16'd2) &&
                      (sh_d[15:0] == 16'd0 || sh_d[15:0] > 16'(MAX_MSG_LEN));
  assign frame_done = ((state_q == MOLD) && sec_end && sh_d[15:0] == 16'd0) ||
                      ((state_q == BODY) && sec_end && last_msg);
  assign emit       = inValid && !inSof && (state_q == BODY) && sec_end && (is_add || is_ex);

`ifdef IP_CHKSUM_EN
  logic [15:0] csum_q, csum_nxt;
  logic [16:0] csum_add;

  always_comb begin
    csum_add = {1'b0, csum_q} + {1'b0, sh_q[7:0], inByte};
    csum_nxt = csum_add[15:0] + {15'd0, csum_add[16]};
  end

  assign csum_bad = (csum_nxt != 16'hFFFF);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                                        csum_q <= '0;
    else if (state_q == ETH)                          csum_q <= '0;
    else if (inValid && state_q == IP && !pos[0])     csum_q <= csum_nxt;
  end
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      cap_q    <= '0;
      len_q    <= '0;
      msgcnt_q <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      valid_q  <= 1'b0;
      type_q   <= '0;
      ref_q    <= '0;
      bs_q     <= '0;
      shares_q <= '0;
      price_q  <= '0;
      stock_q  <= '0;
      seqn_q   <= '0;
      drop_q   <= '0;
      trunc_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (inValid) begin
        sh_q <= sh_d[55:0];
        if (state_q == BODY) cap_q <= cap_d;

        if (inSof) begin
          // A new frame always wins; only an unfinished Mold section counts as truncated.
          if (inLast || state_q inside {MOLD, MLEN, BODY}) trunc_q <= sat_inc(trunc_q);
          state_q <= inLast ? IDLE : ETH;
          cnt_q   <= 16'd1;
        end else if (state_q == TAIL || state_q == DROP) begin
          if (inLast) state_q <= IDLE;
        end else if (state_q != IDLE) begin
          cnt_q <= pos;
          if (state_q == MOLD && pos == 16'd18) seq_q <= sh_d;

          if (hdr_fail) begin
            drop_q  <= sat_inc(drop_q);
            state_q <= inLast ? IDLE : DROP;
          end else if (mold_err) begin
            state_q <= inLast ? IDLE : DROP;
          end else if (inLast && !frame_done) begin
            trunc_q <= sat_inc(trunc_q);
            state_q <= IDLE;
          end else if (sec_end) begin
            cnt_q <= '0;
            case (state_q)
              ETH: state_q <= IP;
              IP:  state_q <= UDP;
              UDP: state_q <= MOLD;
              MOLD: begin
                msgcnt_q <= sh_d[15:0];
                idx_q    <= '0;
                state_q  <= frame_done ? (inLast ? IDLE : TAIL) : MLEN;
              end
              MLEN: begin
                len_q   <= sh_d[15:0];
                state_q <= BODY;
              end
              BODY: begin
                idx_q   <= idx_q + 16'd1;
                state_q <= frame_done ? (inLast ? IDLE : TAIL) : MLEN;
              end
              default: ;
            endcase
          end
        end

        if (emit) begin
          valid_q <= 1'b1;
          type_q  <= d_type;
          ref_q   <= d_ref;
          seqn_q  <= seq_q + {48'd0, idx_q};
          if (d_type == 8'h41) begin
            bs_q     <= d_bs;
            shares_q <= d_shares;
            price_q  <= d_price;
            stock_q  <= d_stock;
          end else begin
            bs_q     <= '0;
            shares_q <= '0;
            price_q  <= '0;
            stock_q  <= '0;
          end
        end
      end
    end
  end

  assign outValid   = valid_q;
  assign outMsgType = type_q;
  assign outRefNum  = ref_q;
  assign outBuySell = bs_q;
  assign outShares  = shares_q;
  assign outPrice   = price_q;
  assign outStock   = stock_q;
  assign outSeqNum  = seqn_q;
  assign dropCnt    = drop_q;
  assign truncCnt   = trunc_q;

endmodule

// File: tb/tb_itch_pkt_parser.sv
// Directed bench for itch_pkt_parser: builds frames byte by byte and checks decoded records and counters.
`timescale 1ns/1ps
module tb_itch_pkt_parser;
  localparam logic [47:0] MAC  = 48'h01005E7D8B20;
  localparam logic [31:0] IPA  = 32'h8AFD8B20;
  localparam logic [15:0] PORT = 16'h4696;
  localparam logic [63:0] AAPL = 64'h4141504C00000000;
  localparam logic [63:0] MSFT = 64'h4D53465400000000;
  localparam logic [63:0] REF1 = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  inByte = '0;
  logic        inValid = 1'b0, inSof = 1'b0, inLast = 1'b0;
  logic        outValid;
  logic [7:0]  outMsgType, outBuySell;
  logic [63:0] outRefNum, outStock, outSeqNum;
  logic [31:0] outShares, outPrice;
  logic [15:0] dropCnt, truncCnt;

  itch_pkt_parser #(
    .MAC_ADDR(MAC), .IP_ADDR(IPA), .UDP_PORT(PORT), .STOCK_FILTER_EN(1'b1),
    .FILTER_STOCK(AAPL), .MAX_MSG_LEN(64), .CNT_W(16)
  ) dut (
    .clk(clk), .rstN(rstN), .inByte(inByte), .inValid(inValid), .inSof(inSof), .inLast(inLast),
    .outValid(outValid), .outMsgType(outMsgType), .outRefNum(outRefNum), .outBuySell(outBuySell),
    .outShares(outShares), .outPrice(outPrice), .outStock(outStock), .outSeqNum(outSeqNum),
    .dropCnt(dropCnt), .truncCnt(truncCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  typ;
    logic [63:0] rnum;
    logic [7:0]  bs;
    logic [31:0] sh;
    logic [31:0] px;
    logic [63:0] stk;
    logic [63:0] seq;
  } rec_t;

  rec_t        recs[$];
  rec_t        mon_r;
  logic [7:0]  frm[$];
  int unsigned vec_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (outValid) begin
      mon_r.typ  = outMsgType;
      mon_r.rnum = outRefNum;
      mon_r.bs   = outBuySell;
      mon_r.sh   = outShares;
      mon_r.px   = outPrice;
      mon_r.stk  = outStock;
      mon_r.seq  = outSeqNum;
      recs.push_back(mon_r);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic put(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  // Eth + IPv4 (valid checksum) + UDP + Mold header; 62 bytes.
  task automatic hdr(input logic [47:0] mac, input logic [15:0] etype, input logic [15:0] port,
                     input logic [63:0] seq, input logic [15:0] cnt);
    logic [31:0] s;
    frm.delete();
    put(64'(mac), 6); put(64'h00AABBCCDDEE, 6); put(64'(etype), 2);
    put(64'h4500, 2); put(64'd100, 2); put(64'h1234, 2); put(64'h4000, 2); put(64'h4011, 2);
    put(64'h0000, 2); put(64'h0A000001, 4); put(64'(IPA), 4);
    s = '0;
    for (int i = 0; i < 10; i++) s += {16'd0, frm[14+2*i], frm[15+2*i]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    frm[24] = ~s[15:8];
    frm[25] = ~s[7:0];
    put(64'h1F90, 2); put(64'(port), 2); put(64'd80, 2); put(64'd0, 2);
    put(64'h5445535453455353, 8); put(64'h3130, 2); put(seq, 8); put(64'(cnt), 2);
  endtask

  task automatic add_msg(input logic [63:0] rnum, input logic [7:0] bs, input logic [31:0] sh,
                         input logic [63:0] stk, input logic [31:0] px, input int len);
    put(64'(len), 2); put(64'h41, 1); put(64'h0001, 2); put(64'h0000, 2); put(64'h000102030405, 6);
    put(rnum, 8); put(64'(bs), 1); put(64'(sh), 4); put(stk, 8); put(64'(px), 4);
    for (int i = 36; i < len; i++) frm.push_back(8'hEE);
  endtask

  task automatic xe_msg(input logic [7:0] typ, input logic [63:0] rnum, input logic [31:0] sh);
    int len;
    len = (typ == 8'h45) ? 31 : 23;
    put(64'(len), 2); put(64'(typ), 1); put(64'h00010000, 4); put(64'h0, 6); put(rnum, 8); put(64'(sh), 4);
    if (typ == 8'h45) put(64'h1, 8);
  endtask

  task automatic std_frame(input logic [63:0] seq);
    hdr(MAC, 16'h0800, PORT, seq, 16'd2);
    add_msg(REF1, 8'h42, 32'd500, AAPL, 32'd1234500, 36);
    xe_msg(8'h58, 64'd7, 32'd100);
  endtask

  task automatic send(input logic stall, input int rst_at, input logic no_last);
    for (int i = 0; i < frm.size(); i++) begin
      if (i == rst_at) begin
        inValid = 1'b0; rstN = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
      end
      inByte = frm[i]; inValid = 1'b1;
      inSof  = (i == 0);
      inLast = !no_last && (i == frm.size() - 1);
      @(posedge clk); #1;
      if (stall) begin
        inValid = 1'b0; inSof = 1'b0; inLast = 1'b0; inByte = 8'hFF;
        @(posedge clk); #1;
      end
    end
    inValid = 1'b0; inSof = 1'b0; inLast = 1'b0;
    if (!no_last) begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_rec(input string tag, input int k, input logic [7:0] typ, input logic [63:0] rnum,
                         input logic [7:0] bs, input logic [31:0] sh, input logic [31:0] px,
                         input logic [63:0] stk, input logic [63:0] seq);
    check({tag, ".present"}, 64'(recs.size() > k), 64'd1);
    if (recs.size() > k) begin
      check({tag, ".type"},   64'(recs[k].typ), 64'(typ));
      check({tag, ".ref"},    recs[k].rnum, rnum);
      check({tag, ".bs"},     64'(recs[k].bs), 64'(bs));
      check({tag, ".shares"}, 64'(recs[k].sh), 64'(sh));
      check({tag, ".price"},  64'(recs[k].px), 64'(px));
      check({tag, ".stock"},  recs[k].stk, stk);
      check({tag, ".seq"},    recs[k].seq, seq);
    end
  endtask

  task automatic exp_std(input string tag, input logic [63:0] seq);
    check({tag, ".count"}, 64'(recs.size()), 64'd2);
    exp_rec({tag, ".add"}, 0, 8'h41, REF1, 8'h42, 32'd500, 32'd1234500, AAPL, seq);
    exp_rec({tag, ".cxl"}, 1, 8'h58, 64'd7, 8'h00, 32'd0, 32'd0, 64'd0, seq + 64'd1);
  endtask

  task automatic exp_cnt(input string tag, input logic [15:0] drop, input logic [15:0] trunc);
    check({tag, ".drop"},  64'(dropCnt), 64'(drop));
    check({tag, ".trunc"}, 64'(truncCnt), 64'(trunc));
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 64'(outValid), 64'd0);
    check("rst.type",  64'(outMsgType), 64'd0);
    check("rst.ref",   outRefNum, 64'd0);
    check("rst.seq",   outSeqNum, 64'd0);
    exp_cnt("rst", 16'd0, 16'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    recs.delete(); std_frame(64'd100); send(1'b0, -1, 1'b0);
    exp_std("t1", 64'd100);
    check("t1.hold", 64'(outMsgType), 64'h58);
    exp_cnt("t1", 16'd0, 16'd0);

    recs.delete();
    hdr(48'h010203040506, 16'h0800, PORT, 64'd1, 16'd1); add_msg(REF1, 8'h42, 32'd1, AAPL, 32'd1, 36);
    send(1'b0, -1, 1'b0);
    exp_cnt("drop_mac", 16'd1, 16'd0);
    hdr(MAC, 16'h86DD, PORT, 64'd1, 16'd1); add_msg(REF1, 8'h42, 32'd1, AAPL, 32'd1, 36);
    send(1'b0, -1, 1'b0);
    exp_cnt("drop_v6", 16'd2, 16'd0);
    hdr(MAC, 16'h0800, 16'h2710, 64'd1, 16'd1); add_msg(REF1, 8'h42, 32'd1, AAPL, 32'd1, 36);
    send(1'b0, -1, 1'b0);
    exp_cnt("drop_port", 16'd3, 16'd0);
    check("drop.count", 64'(recs.size()), 64'd0);

    recs.delete();
    hdr(MAC, 16'h0800, PORT, 64'd200, 16'd2);
    add_msg(64'd55, 8'h53, 32'd10, MSFT, 32'd999, 36);
    xe_msg(8'h45, 64'd9, 32'd50);
    send(1'b0, -1, 1'b0);
    check("filt.count", 64'(recs.size()), 64'd1);
    exp_rec("filt.exe", 0, 8'h45, 64'd9, 8'h00, 32'd0, 32'd0, 64'd0, 64'd201);

    recs.delete();
    hdr(MAC, 16'h0800, PORT, 64'd250, 16'd1); add_msg(REF1, 8'h42, 32'd500, AAPL, 32'd1234500, 36);
    while (frm.size() > 84) void'(frm.pop_back());
    send(1'b0, -1, 1'b0);
    check("trunc.count", 64'(recs.size()), 64'd0);
    exp_cnt("trunc", 16'd3, 16'd1);
    std_frame(64'd300); send(1'b0, -1, 1'b0);
    exp_std("after_trunc", 64'd300);

    recs.delete(); std_frame(64'd400); send(1'b1, -1, 1'b0);
    exp_std("stall", 64'd400);

    recs.delete();
    frm.delete(); frm.push_back(8'h01); send(1'b0, -1, 1'b0);
    exp_cnt("one_byte", 16'd3, 16'd2);
    std_frame(64'd450);
    while (frm.size() > 80) void'(frm.pop_back());
    send(1'b0, -1, 1'b1);
    std_frame(64'd500); send(1'b0, -1, 1'b0);
    exp_std("abort", 64'd500);
    exp_cnt("abort", 16'd3, 16'd3);

    recs.delete();
    hdr(MAC, 16'h0800, PORT, 64'd550, 16'd0); put(64'hDEADBEEF, 4);
    send(1'b0, -1, 1'b0);
    hdr(MAC, 16'h0800, PORT, 64'd560, 16'd1); add_msg(REF1, 8'h42, 32'd5, AAPL, 32'd6, 65);
    send(1'b0, -1, 1'b0);
    check("edge.count", 64'(recs.size()), 64'd0);
    exp_cnt("edge", 16'd3, 16'd3);
    hdr(MAC, 16'h0800, PORT, 64'd600, 16'd1); add_msg(64'd77, 8'h53, 32'd300, AAPL, 32'd4200, 64);
    send(1'b0, -1, 1'b0);
    check("len64.count", 64'(recs.size()), 64'd1);
    exp_rec("len64", 0, 8'h41, 64'd77, 8'h53, 32'd300, 32'd4200, AAPL, 64'd600);

    recs.delete(); std_frame(64'd700); send(1'b0, 73, 1'b0);
    check("rstmid.count", 64'(recs.size()), 64'd0);
    check("rstmid.type",  64'(outMsgType), 64'd0);
    check("rstmid.seq",   outSeqNum, 64'd0);
    exp_cnt("rstmid", 16'd0, 16'd0);
    std_frame(64'd800); send(1'b0, -1, 1'b0);
    exp_std("after_rst", 64'd800);

`ifdef IP_CHKSUM_EN
    recs.delete(); std_frame(64'd900); send(1'b0, -1, 1'b0);
    exp_std("csum_ok", 64'd900);
    recs.delete(); std_frame(64'd950); frm[25] = frm[25] + 8'd1; send(1'b0, -1, 1'b0);
    check("csum_bad.count", 64'(recs.size()), 64'd0);
    exp_cnt("csum_bad", 16'd1, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
